// File: rtl/beat_timing_gen_if.sv
// beat_timing_gen_if
//   Link between the beat generator and the hardwired controller `cpu`.
//   Signals:
//     w1, w2, w3  beat lines, generator -> cpu (one-hot while running, all 0 when halted)
//     short       cpu -> generator: end the machine cycle after W1
//     long        cpu -> generator: extend the machine cycle to W3
//     stop        cpu -> generator: halt at the end of the current machine cycle
//   Modports:
//     master  beat generator side (drives w*, samples short/long/stop)
//     slave   cpu side (samples w*, drives short/long/stop)
//
// Link contract: there is no valid/ready pair. The beat lines act as the
// "valid" of each beat and are always accepted. The cpu answers with
// short/long/stop, which are level signals. The generator samples them
// only at the t3 rising edge that ends the current beat. Outside RUN they
// are don't-care.
interface beat_timing_gen_if;
    logic w1;
    logic w2;
    logic w3;
    logic short;
    logic long;
    logic stop;

    modport master (
        output w1, w2, w3,
        input  short, long, stop
    );

    modport slave (
        input  w1, w2, w3,
        output short, long, stop
    );
endinterface

// File: rtl/beat_timing_gen.sv
// beat_timing_gen
//   W-phase beat generator for the hardwired controller `cpu`.
//   It produces the one-hot beats w1/w2/w3. The cpu feedback can shorten a
//   machine cycle to W1 only, extend it to W3, or request a halt at the
//   cycle end. The front-panel QD key starts the machine. step_mode halts
//   the machine after every machine cycle.
//   Ports:
//     t3          clock, rising edge
//     clr         synchronous active-high reset; overrides every other input
//     qd          debounced start key level; its rising edge starts the machine from HALT
//     step_mode   1 = halt after every machine cycle (sampled at the cycle end)
//     bus         beat/feedback link to the cpu (master side)
//     running     1 while a beat is active
//     cycle_done  one-cycle pulse after each completed machine cycle
//     cycle_cnt   completed machine cycles, wraps at 2^CNT_W
//     dbg_state   current FSM state, for observation only
module beat_timing_gen #(
    parameter int CNT_W = 16
) (
    input  logic                 t3,
    input  logic                 clr,
    input  logic                 qd,
    input  logic                 step_mode,
    beat_timing_gen_if.master    bus,
    output logic                 running,
    output logic                 cycle_done,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_W1   = 2'd1,
        S_W2   = 2'd2,
        S_W3   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   qd_d;
    logic   qd_rise;
    logic   stop_pend;
    logic   stop_pend_nxt;
    logic   cyc_end;
    logic   w1_q;
    logic   w2_q;
    logic   w3_q;

    // A held key yields a single start: only the 0->1 transition counts.
    assign qd_rise = qd & ~qd_d;

    always_comb begin
        state_nxt     = state;
        stop_pend_nxt = stop_pend;
        cyc_end       = 1'b0;

        case (state)
            S_HALT: if (qd_rise) state_nxt = S_W1;
            S_W1: begin
                // short has priority over long in W1
                if (bus.short) cyc_end = 1'b1;
                else           state_nxt = S_W2;
            end
            S_W2: begin
                if (bus.long) state_nxt = S_W3;
                else          cyc_end   = 1'b1;
            end
            S_W3:    cyc_end   = 1'b1;
            default: state_nxt = S_HALT;
        endcase

        // stop is latched at every RUN edge, the ending edge included.
        // The halt decision below therefore sees a stop sampled at this edge.
        if (state != S_HALT) stop_pend_nxt = stop_pend | bus.stop;

        if (cyc_end) begin
            if (stop_pend_nxt || step_mode) begin
                state_nxt     = S_HALT;
                stop_pend_nxt = 1'b0;
            end else begin
                state_nxt = S_W1;
            end
        end
    end

    // The beats and status are registered from next-state so that they
    // change cleanly at the edge together with the state.
    always_ff @(posedge t3) begin
        if (clr) begin
            state      <= S_HALT;
            qd_d       <= 1'b0;
            stop_pend  <= 1'b0;
            w1_q       <= 1'b0;
            w2_q       <= 1'b0;
            w3_q       <= 1'b0;
            running    <= 1'b0;
            cycle_done <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            qd_d       <= qd;
            stop_pend  <= stop_pend_nxt;
            w1_q       <= (state_nxt == S_W1);
            w2_q       <= (state_nxt == S_W2);
            w3_q       <= (state_nxt == S_W3);
            running    <= (state_nxt != S_HALT);
            cycle_done <= cyc_end;
            if (cyc_end) cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    assign bus.w1    = w1_q;
    assign bus.w2    = w2_q;
    assign bus.w3    = w3_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_beat_timing_gen.sv
module tb_beat_timing_gen;

    logic t3 = 1'b0;
    always #5 t3 = ~t3;

    logic        clr;
    logic        qd;
    logic        step_mode;
    logic        running;
    logic        cycle_done;
    logic [15:0] cycle_cnt;
    logic [1:0]  dbg_state;
    logic        running_s;
    logic        cycle_done_s;
    logic [1:0]  cycle_cnt_s;
    logic [1:0]  dbg_state_s;

    beat_timing_gen_if bif ();
    beat_timing_gen_if bif_s ();

    beat_timing_gen #(.CNT_W(16)) dut (
        .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode), .bus(bif),
        .running(running), .cycle_done(cycle_done), .cycle_cnt(cycle_cnt),
        .dbg_state(dbg_state)
    );

    // Narrow counter copy driven by the same stimulus, used to exercise the wrap.
    beat_timing_gen #(.CNT_W(2)) dut_s (
        .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode), .bus(bif_s),
        .running(running_s), .cycle_done(cycle_done_s), .cycle_cnt(cycle_cnt_s),
        .dbg_state(dbg_state_s)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [1:0] halt_code;
    logic [1:0] halt_code_s;
    bit         halt_known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit c, input bit q, input bit s, input bit sh, input bit lg, input bit st);
        @(negedge t3);
        clr = c; qd = q; step_mode = s;
        bif.short = sh; bif.long = lg; bif.stop = st;
        bif_s.short = sh; bif_s.long = lg; bif_s.stop = st;
        @(posedge t3);
        #1;
        cyc++;
    endtask

    task automatic compare(input logic [2:0] ew, input bit erun, input bit edone, input int ecnt);
        check("w",          {29'd0, bif.w1, bif.w2, bif.w3}, {29'd0, ew});
        check("running",    {31'd0, running},    {31'd0, erun});
        check("cycle_done", {31'd0, cycle_done}, {31'd0, edone});
        check("cycle_cnt",  {16'd0, cycle_cnt},  ecnt % 65536);
        check("w_s",        {29'd0, bif_s.w1, bif_s.w2, bif_s.w3}, {29'd0, ew});
        check("cycle_cnt_s",{30'd0, cycle_cnt_s}, ecnt % 4);
        check("running_s",  {31'd0, running_s},  {31'd0, erun});
        check("cycle_done_s",{31'd0, cycle_done_s}, {31'd0, edone});
        if (halt_known) begin
            check("dbg_state", {31'd0, dbg_state != halt_code}, {31'd0, erun});
            check("dbg_state_s", {31'd0, dbg_state_s != halt_code_s}, {31'd0, erun});
        end
    endtask

    typedef struct {
        bit         clr, qd, step, sh, lg, st;
        logic [2:0] w;
        bit         run, done;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit c, input bit q, input bit s, input bit sh, input bit lg, input bit st,
                       input logic [2:0] w, input bit run, input bit done, input int cnt);
        vec_t v;
        v.clr = c; v.qd = q; v.step = s; v.sh = sh; v.lg = lg; v.st = st;
        v.w = w; v.run = run; v.done = done; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Reference model: the machine position is the beat number within the
    // current machine cycle (0 = halted).
    int m_beat;
    bit m_pend;
    int m_cnt;
    bit m_qd_prev;
    bit m_done;

    task automatic model_step(input bit c, input bit q, input bit s, input bit sh, input bit lg, input bit st);
        bit rise;
        bit ends;
        if (c) begin
            m_beat = 0; m_pend = 0; m_cnt = 0; m_qd_prev = 0; m_done = 0;
            return;
        end
        rise = q && !m_qd_prev;
        m_qd_prev = q;
        m_done = 0;
        if (m_beat == 0) begin
            if (rise) m_beat = 1;
        end else begin
            m_pend = m_pend || st;
            ends = (m_beat == 1 && sh) || (m_beat == 2 && !lg) || (m_beat == 3);
            if (ends) begin
                m_cnt = (m_cnt + 1) % 65536;
                m_done = 1;
                if (m_pend || s) begin
                    m_beat = 0;
                    m_pend = 0;
                end else begin
                    m_beat = 1;
                end
            end else begin
                m_beat = m_beat + 1;
            end
        end
    endtask

    function automatic logic [2:0] beat_to_w(input int b);
        return (b == 0) ? 3'b000 : 3'(3'b100 >> (b - 1));
    endfunction

    initial begin
        bit rc, rq, rs, rsh, rlg, rst;
        clr = 1'b1; qd = 1'b0; step_mode = 1'b0;
        bif.short = 1'b0; bif.long = 1'b0; bif.stop = 1'b0;
        bif_s.short = 1'b0; bif_s.long = 1'b0; bif_s.stop = 1'b0;

        // clr qd step short long stop | w run done cnt
        add(1,0,0,0,0,0, 3'b000,0,0,0);
        add(1,0,0,0,0,0, 3'b000,0,0,0);
        add(0,1,0,0,0,0, 3'b100,1,0,0);
        add(0,1,0,0,0,0, 3'b010,1,0,0);
        add(0,1,0,0,0,0, 3'b100,1,1,1);
        add(0,1,0,0,0,0, 3'b010,1,0,1);
        add(0,1,0,0,0,0, 3'b100,1,1,2);
        add(0,0,0,0,0,0, 3'b010,1,0,2);
        add(0,0,0,1,0,0, 3'b100,1,1,3);
        add(0,0,0,1,0,0, 3'b100,1,1,4);
        add(0,0,0,1,0,0, 3'b100,1,1,5);
        add(0,0,0,0,1,0, 3'b010,1,0,5);
        add(0,0,0,0,1,0, 3'b001,1,0,5);
        add(0,0,0,0,1,0, 3'b100,1,1,6);
        add(0,0,0,1,1,0, 3'b100,1,1,7);
        add(0,0,0,0,1,1, 3'b010,1,0,7);
        add(0,0,0,0,1,0, 3'b001,1,0,7);
        add(0,0,0,0,1,0, 3'b000,0,1,8);
        add(0,0,0,0,0,0, 3'b000,0,0,8);
        add(0,1,0,0,0,0, 3'b100,1,0,8);
        add(0,0,0,1,0,0, 3'b100,1,1,9);
        add(0,1,0,0,0,0, 3'b010,1,0,9);
        add(0,0,0,0,0,1, 3'b000,0,1,10);
        add(0,0,0,0,0,1, 3'b000,0,0,10);
        add(0,1,0,0,0,0, 3'b100,1,0,10);
        add(0,1,0,1,0,0, 3'b100,1,1,11);
        add(0,1,0,0,0,0, 3'b010,1,0,11);
        add(1,1,0,0,0,0, 3'b000,0,0,0);
        add(0,1,0,0,0,0, 3'b100,1,0,0);
        add(0,1,1,0,1,0, 3'b010,1,0,0);
        add(0,1,1,0,1,0, 3'b001,1,0,0);
        add(0,1,1,0,1,0, 3'b000,0,1,1);
        add(0,0,1,0,1,0, 3'b000,0,0,1);
        add(0,1,1,0,1,0, 3'b100,1,0,1);
        add(0,0,1,0,1,0, 3'b010,1,0,1);
        add(0,0,1,0,1,0, 3'b001,1,0,1);
        add(0,0,1,0,1,0, 3'b000,0,1,2);
        add(0,1,1,0,1,0, 3'b100,1,0,2);
        add(0,0,1,0,1,0, 3'b010,1,0,2);
        add(0,0,1,0,1,0, 3'b001,1,0,2);
        add(0,0,1,0,1,0, 3'b000,0,1,3);
        add(0,1,1,0,0,0, 3'b100,1,0,3);
        add(0,1,0,0,0,0, 3'b010,1,0,3);
        add(0,1,0,0,0,0, 3'b100,1,1,4);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].qd, vecs[i].step, vecs[i].sh, vecs[i].lg, vecs[i].st);
            compare(vecs[i].w, vecs[i].run, vecs[i].done, vecs[i].cnt);
            if (i == 0) begin
                halt_code   = dbg_state;
                halt_code_s = dbg_state_s;
                halt_known  = 1'b1;
            end
        end

        // A pending stop must not survive a reset.
        drive(1,0,0,0,0,0); compare(3'b000,0,0,0);
        drive(0,1,0,0,1,0); compare(3'b100,1,0,0);
        drive(0,1,0,0,1,1); compare(3'b010,1,0,0);
        drive(1,1,0,0,1,0); compare(3'b000,0,0,0);
        drive(0,0,0,0,0,0); compare(3'b000,0,0,0);
        drive(0,1,0,0,0,0); compare(3'b100,1,0,0);
        drive(0,1,0,0,0,0); compare(3'b010,1,0,0);
        drive(0,1,0,0,0,0); compare(3'b100,1,1,1);

        // Randomized run against the model.
        model_step(1,0,0,0,0,0);
        drive(1,0,0,0,0,0);
        compare(beat_to_w(m_beat), m_beat != 0, m_done, m_cnt);
        rq = 0; rs = 0;
        for (int n = 0; n < 3000; n++) begin
            rc  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 4) == 0) rq = ~rq;
            if ($urandom_range(0, 63) == 0) rs = ~rs;
            rsh = ($urandom_range(0, 3) == 0);
            rlg = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 19) == 0);
            model_step(rc, rq, rs, rsh, rlg, rst);
            drive(rc, rq, rs, rsh, rlg, rst);
            compare(beat_to_w(m_beat), m_beat != 0, m_done, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beat_timing_gen.md
Name: beat_timing_gen

Overview:
Beat (W-phase) generator that sits directly upstream of the hardwired controller `cpu`.
- Produces the one-hot beat signals w1/w2/w3 that `cpu` consumes.
- Consumes the `cpu` feedback outputs short, long and stop, which shorten, extend or halt the machine cycle.
- Runs on the same t3 clock as `cpu` and provides start/halt control from the front-panel QD (start) key plus a single-cycle step mode.

Parameters:
- CNT_W, 16, width of the completed-machine-cycle counter.

Ports:
- t3  input  1  clock; all state changes on rising edge.
- clr  input  1  reset; synchronous, active-high.
- qd  input  1  start key level, already debounced and synchronous to t3.
- step_mode  input  1  1 = halt after every machine cycle.
- short  input  1  from `cpu`: end the machine cycle after W1.
- long  input  1  from `cpu`: extend the machine cycle to W3.
- stop  input  1  from `cpu`: halt at the end of the current machine cycle.
- w1  output  1  beat 1.
- w2  output  1  beat 2.
- w3  output  1  beat 3.
- running  output  1  1 while in RUN.
- cycle_done  output  1  one-cycle pulse after each completed machine cycle.
- cycle_cnt  output  CNT_W  count of completed machine cycles.

Behaviour:
- Reset (clr=1 at an edge, in any state, mid-cycle included):
  - state=HALT; w1=w2=w3=0; running=0; cycle_done=0.
  - cycle_cnt=0; qd_d=0; stop_pend=0.
  - clr has priority over every other input.
- Start detect: qd_d <= qd each edge; qd_rise = qd & ~qd_d. A held key produces exactly one start.
- All outputs are registered. In HALT all w are 0. In RUN exactly one of w1/w2/w3 is 1.
- HALT:
  - On qd_rise, the next cycle enters RUN with w1=1 and running=1.
  - stop, short and long are ignored in HALT.
- RUN, at each edge, based on the current beat and inputs sampled at that edge:
  - W1: short=1 ends the cycle; otherwise go to W2. short beats long if both are 1.
  - W2: long=1 goes to W3; otherwise the cycle ends.
  - W3: the cycle always ends; long is ignored.
- stop_pend:
  - Set when stop=1 is sampled at any RUN edge, including the ending edge.
  - Sticky until HALT is entered.
- Cycle end (same edge):
  - cycle_cnt <= cycle_cnt+1, wrapping at 2^CNT_W; cycle_done <= 1.
  - If stop_pend, stop at this edge, or step_mode=1: go to HALT (all w=0, running=0, stop_pend cleared).
  - Otherwise go to W1 of the next machine cycle.
- cycle_done is 0 at every edge that is not a cycle end.
- qd_rise during RUN is ignored; it does not restart or extend the cycle.
- step_mode is sampled only at cycle end, so changing it mid-cycle takes effect at that cycle's end.
- Latency:
  - qd_rise to w1=1: 1 cycle.
  - Machine cycle is 1, 2 or 3 t3 cycles.
  - Consecutive machine cycles have no idle beat between them.

Test Plan:
- Reset/start:
  - clr=1 for 2 cycles: outputs all 0, cycle_cnt=0.
  - qd 0->1 held 5 cycles, short=long=stop=0: w sequence W1,W2,W1,W2,... with a single start only; cycle_cnt=2 after 4 cycles.
- Short/long:
  - short=1 during W1: W1 repeats every cycle and cycle_done is high each cycle.
  - long=1 during W2: sequence W1,W2,W3,W1; cycle_cnt +1 per 3 cycles.
  - short=long=1 during W1: short wins, next beat is W1.
- Stop:
  - stop pulsed 1 cycle during W1 of a 3-beat cycle: W2,W3 complete, then HALT; running=0, cycle_cnt +1.
  - Further qd edge resumes at W1.
- Step mode: step_mode=1 with long=1 and 3 qd presses: three W1..W3 cycles each followed by HALT; cycle_cnt=3.
- Mid-operation reset and wrap:
  - clr=1 during W2: next cycle all 0, running=0, cycle_cnt=0.
  - CNT_W=2, 5 short cycles: cycle_cnt wraps 3->0->1.
